// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin scheduler sharing one registered two-operand adder
// among NUM_REQ requesters. It tracks in-flight tags and routes each sum back to
// the requester that issued it. i_pause drains the pipeline before the adder
// enable drops.
// Optional feature: define ADDER_RR_SCHED_STATS_EN to add o_grant_cnt, which
// holds per-requester saturating handshake counters.
`timescale 1ns/1ps
module adder_rr_sched #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_REQ       = 4,
  parameter int ADDER_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [1:0]                      o_adder_valid,
  output logic [2*DATA_WIDTH-1:0]         o_adder_data,
  output logic                            o_adder_en,
  input  logic                            i_adder_valid,
  input  logic [DATA_WIDTH-1:0]           i_adder_data,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]           o_rsp_data,
  input  logic                            i_pause,
  output logic                            o_idle,
`ifdef ADDER_RR_SCHED_STATS_EN
  output logic [NUM_REQ*16-1:0]           o_grant_cnt,
`endif
  output logic                            o_err
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DEPTH = 1 + ADDER_LATENCY;
  localparam int FL_W  = $clog2(ADDER_LATENCY + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PAUSED} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q;
  logic [1:0]              adder_valid_q;
  logic [2*DATA_WIDTH-1:0] adder_data_q;
  logic [DEPTH-1:0]        tag_vld_q;
  logic [IDX_W-1:0]        tag_idx_q [DEPTH];
  logic [FL_W-1:0]         flush_q;
  logic                    err_q;

  logic [2*DATA_WIDTH-1:0] req_pair [NUM_REQ];
  logic                    grant_found;
  logic [IDX_W-1:0]        grant_idx;
  logic                    exp_vld;
  logic [IDX_W-1:0]        exp_idx;
  logic                    drain_done;
  logic                    err_set;

  // Unpack each requester's {a,b} pair from the flat input bus.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pair
    assign req_pair[gi] = i_req_data[gi*2*DATA_WIDTH +: 2*DATA_WIDTH];
  end

  // Round-robin search from pointer+1; grants only in RUN with no pause request.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    if (state_q == ST_RUN && !i_pause) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        cand     = (int'(ptr_q) + off) % NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (!grant_found && i_req_valid[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // One-hot ready from the granted index.
  always_comb begin
    o_req_ready = '0;
    if (grant_found) o_req_ready[grant_idx] = 1'b1;
  end

  // Pipeline may drain once no tag is behind the one retiring this cycle.
  assign drain_done = ~|tag_vld_q[DEPTH-2:0];
  assign exp_vld    = tag_vld_q[DEPTH-1];
  assign exp_idx    = tag_idx_q[DEPTH-1];

  // Next-state logic: pause passes through DRAIN so in-flight sums still return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (i_pause) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_pause)        state_d = ST_RUN;
        else if (drain_done) state_d = ST_PAUSED;
      end
      ST_PAUSED: if (!i_pause) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // State register and round-robin pointer (pointer moves only on handshake).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (grant_found) ptr_q <= grant_idx;
    end
  end

  // Issue register: the accepted pair is presented to the adder the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      adder_valid_q <= 2'b00;
      adder_data_q  <= '0;
    end else begin
      adder_valid_q <= grant_found ? 2'b11 : 2'b00;
      adder_data_q  <= grant_found ? req_pair[grant_idx] : '0;
    end
  end

  // Tag shift register; the last stage lines up with the adder output.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int s = 0; s < DEPTH; s++) tag_idx_q[s] <= '0;
    end else begin
      tag_vld_q    <= {tag_vld_q[DEPTH-2:0], grant_found};
      tag_idx_q[0] <= grant_idx;
      for (int s = 1; s < DEPTH; s++) tag_idx_q[s] <= tag_idx_q[s-1];
    end
  end

  // Post-reset window: results the adder was already computing are ignored.
  always_ff @(posedge clk) begin
    if (rst)                 flush_q <= FL_W'(ADDER_LATENCY);
    else if (flush_q != '0)  flush_q <= flush_q - 1'b1;
  end

  assign err_set = (flush_q == '0) &&
                   ((o_adder_en && (i_adder_valid != exp_vld)) ||
                    ((state_q == ST_PAUSED) && i_adder_valid));

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  // Route the adder result to the requester recorded in the retiring tag.
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    if (i_adder_valid && exp_vld) begin
      o_rsp_valid[exp_idx] = 1'b1;
      o_rsp_data           = i_adder_data;
    end
  end

  assign o_adder_valid = adder_valid_q;
  assign o_adder_data  = adder_data_q;
  assign o_adder_en    = (state_q != ST_PAUSED);
  assign o_idle        = ~|tag_vld_q;
  assign o_err         = err_q;

`ifdef ADDER_RR_SCHED_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [15:0] cnt_q;
    // Saturating count of accepted handshakes for this requester.
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else if (grant_found && grant_idx == IDX_W'(gi) && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
    assign o_grant_cnt[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// Testbench for adder_rr_sched: directed scenarios followed by a random phase.
// The outputs are compared each cycle against a transaction-level reference
// model that uses a queue of pending results.
`timescale 1ns/1ps
module tb_adder_rr_sched;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int L  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [2*DW-1:0]   req_pair [NR];
  logic [NR*2*DW-1:0] req_data;
  logic [NR-1:0]     o_req_ready;
  logic [1:0]        o_adder_valid;
  logic [2*DW-1:0]   o_adder_data;
  logic              o_adder_en;
  logic              adder_v_q = 1'b0;
  logic [DW-1:0]     adder_d_q = '0;
  logic              inj;
  logic              adder_valid_in;
  logic [NR-1:0]     o_rsp_valid;
  logic [DW-1:0]     o_rsp_data;
  logic              pause;
  logic              o_idle;
  logic              o_err;
`ifdef ADDER_RR_SCHED_STATS_EN
  logic [NR*16-1:0]  o_grant_cnt;
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign req_data[gi*2*DW +: 2*DW] = req_pair[gi];
  end

  // External registered adder with enable; it is not reset, so a result
  // that is in flight at reset still shows up one cycle later.
  always @(posedge clk) begin
    if (o_adder_en === 1'b1) begin
      adder_v_q <= &o_adder_valid;
      adder_d_q <= o_adder_data[2*DW-1:DW] + o_adder_data[DW-1:0];
    end
  end
  assign adder_valid_in = adder_v_q | inj;

  adder_rr_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADDER_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(o_req_ready),
    .o_adder_valid(o_adder_valid), .o_adder_data(o_adder_data), .o_adder_en(o_adder_en),
    .i_adder_valid(adder_valid_in), .i_adder_data(adder_d_q),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .i_pause(pause), .o_idle(o_idle),
`ifdef ADDER_RR_SCHED_STATS_EN
    .o_grant_cnt(o_grant_cnt),
`endif
    .o_err(o_err)
  );

  // Reference model state.
  typedef struct { int due; int idx; logic [DW-1:0] sum; } exp_t;
  exp_t            pend [$];
  int              cyc;
  int              mptr;
  logic            pause_prev;
  logic            m_paused;
  logic            m_err;
  logic [1:0]      exp_av;
  logic [2*DW-1:0] exp_ad;
  int              rsp_cnt [NR];
  logic            quiet;
  int              checks;
  int              failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // First requester with valid set, searching upward from ptr+1 with wraparound.
  function automatic int model_grant(input logic [NR-1:0] v, input int ptr);
    int c;
    for (int off = 1; off <= NR; off++) begin
      c = (ptr + off) % NR;
      if (((v >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    mptr = NR - 1; pause_prev = 1'b0; m_paused = 1'b0; m_err = 1'b0;
    exp_av = 2'b00; exp_ad = '0;
  endtask

  // One clock cycle: check all outputs against the model, then advance the model.
  task automatic tick();
    int g;
    logic [NR-1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] s;
    logic          inj_s, rst_s;
    #2;
    g = (!pause && !pause_prev) ? model_grant(req_valid, mptr) : -1;
    exp_rv = '0; exp_rd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv = NR'(1) << pend[0].idx;
      exp_rd = pend[0].sum;
    end
    chk("ready", o_req_ready, (g >= 0) ? (NR'(1) << g) : '0);
    chk("adder_valid", o_adder_valid, exp_av);
    chk("adder_data", o_adder_data, exp_ad);
    chk("adder_en", o_adder_en, !m_paused);
    chk("rsp_valid", o_rsp_valid, exp_rv);
    chk("rsp_data", o_rsp_data, exp_rd);
    chk("idle", o_idle, pend.size() == 0);
    chk("err", o_err, m_err);
    for (int k = 0; k < NR; k++)
      if (((o_rsp_valid >> k) & 4'd1) != 4'd0) rsp_cnt[k]++;
    if (g >= 0 && !quiet)
      $display("cyc=%0d grant req=%0d a=%h b=%h", cyc, g, req_pair[g][2*DW-1:DW], req_pair[g][DW-1:0]);
    inj_s = inj; rst_s = rst;
    @(posedge clk);
    #1;
    if (rst_s) begin
      model_reset();
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
      if (g >= 0) begin
        s = req_pair[g][2*DW-1:DW] + req_pair[g][DW-1:0];
        pend.push_back('{due: cyc + 1 + L, idx: g, sum: s});
        mptr = g; exp_av = 2'b11; exp_ad = req_pair[g];
      end else begin
        exp_av = 2'b00; exp_ad = '0;
      end
      m_paused = pause && pause_prev && (pend.size() == 0);
      if (inj_s) m_err = 1'b1;
      pause_prev = pause;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NR; k++) rsp_cnt[k] = 0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; quiet = 1'b0;
    rst = 1'b1; req_valid = '0; pause = 1'b0; inj = 1'b0;
    for (int k = 0; k < NR; k++) begin req_pair[k] = '0; rsp_cnt[k] = 0; end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state.
    #1;
    chk("reset_adder_en", o_adder_en, 1'b1);
    chk("reset_idle", o_idle, 1'b1);
    chk("reset_adder_valid", o_adder_valid, 2'b00);
    tick();

    // Single request from requester 2: 5 + 7.
    req_pair[2] = {16'd5, 16'd7}; req_valid = 4'b0100;
    #1 chk("single_ready", o_req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #1 chk("single_adder_valid", o_adder_valid, 2'b11);
    chk("single_adder_data", o_adder_data, {16'd5, 16'd7});
    tick();
    #1 chk("single_rsp_valid", o_rsp_valid, 4'b0100);
    chk("single_rsp_data", o_rsp_data, 16'd12);
    tick();
    tick();

    // Fairness: all requesters valid for 8 cycles after reset.
    do_reset();
    for (int k = 0; k < NR; k++) req_pair[k] = {16'($urandom), 16'($urandom)};
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk("fair_order", o_req_ready, NR'(1) << (i % NR));
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    for (int k = 0; k < NR; k++) chk("fair_results", rsp_cnt[k], 2);

    // Overflow wraps to DATA_WIDTH bits (pointer is at 3, so requester 1 is granted).
    req_pair[1] = {16'hFFFF, 16'h0002}; req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    #1 chk("ovf_rsp_data", o_rsp_data, 16'h0001);
    chk("ovf_rsp_valid", o_rsp_valid, 4'b0010);
    tick(); tick();
    #1 chk("ovf_no_err", o_err, 1'b0);

    // Pause/drain: grants 2,3,0 back to back, then pause.
    req_valid = 4'b1111;
    repeat (3) tick();
    pause = 1'b1;
    #1 chk("pause_blocks_grant", o_req_ready, 4'b0000);
    tick();
    tick();
    #1 chk("paused_adder_en", o_adder_en, 1'b0);
    chk("paused_idle", o_idle, 1'b1);
    tick();
    pause = 1'b0;
    tick();
    #1 chk("resume_after_last", o_req_ready, 4'b0010);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Reset one cycle after a handshake (pointer at 1, so requester 3 is granted).
    req_pair[3] = {16'h1234, 16'h1111}; req_valid = 4'b1000;
    tick();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_err", o_err, 1'b0);
    req_valid = 4'b1111;
    #1 chk("rst_ptr_restart", o_req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Spurious adder valid with nothing in flight.
    inj = 1'b1;
    tick();
    inj = 1'b0;
    repeat (3) tick();
    chk("err_sticky", o_err, 1'b1);
    do_reset();
    #1 chk("err_cleared", o_err, 1'b0);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      req_valid = NR'($urandom);
      for (int k = 0; k < NR; k++) req_pair[k] = {16'($urandom), 16'($urandom)};
      pause = ($urandom_range(0, 9) < 2);
      tick();
    end
    pause = 1'b0; req_valid = '0;
    repeat (4) tick();

`ifdef ADDER_RR_SCHED_STATS_EN
    do_reset();
    quiet = 1'b1;
    req_valid = 4'b0001;
    repeat (66000) tick();
    req_valid = '0;
    repeat (3) tick();
    chk("stats_sat_req0", o_grant_cnt[15:0], 16'hFFFF);
    chk("stats_req1", o_grant_cnt[31:16], 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
